// File: rtl/mux_scan_reg_pkg.sv
// Shared types and helpers for the registered channel mux (package mux_pkg).
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } mux_state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Pointer/select width; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_reg_if.sv
// Control/data bundle for mux_scan_reg. sel_err exists only with MUX_SEL_ERR_EN.
interface mux_scan_reg_if #(
    parameter int N_IN = 6,
    parameter int W    = 1
);
    import mux_pkg::*;

    localparam int SELW = sel_width(N_IN);

    logic                en;
    logic                mode;
    logic                freeze;
    logic [SELW-1:0]     sel;
    logic [N_IN*W-1:0]   in_data;
    logic [N_IN-1:0]     in_valid;
    logic [W-1:0]        out_data;
    logic                out_valid;
    logic [SELW-1:0]     out_ch;
    logic                scan_wrap;
`ifdef MUX_SEL_ERR_EN
    logic                sel_err;
`endif

    modport master (
        output en, mode, freeze, sel, in_data, in_valid,
        input  out_data, out_valid, out_ch, scan_wrap
`ifdef MUX_SEL_ERR_EN
        , sel_err
`endif
    );

    modport slave (
        input  en, mode, freeze, sel, in_data, in_valid,
        output out_data, out_valid, out_ch, scan_wrap
`ifdef MUX_SEL_ERR_EN
        , sel_err
`endif
    );

endinterface

// File: rtl/mux_scan_reg_dwell_cnt.sv
// Per-channel dwell counter: tick marks the last cycle of a channel's dwell.
module mux_dwell_cnt
    import mux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int CW = sel_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    // clr wins over the wrap so a fresh scan always starts a full dwell.
    assign tick = (cnt == LAST) && !hold && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (!hold)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/mux_scan_reg.sv
// Registered N_IN x W channel mux with manual select and auto-scan.
// Optional sticky out-of-range select flag under `MUX_SEL_ERR_EN.
module mux_scan_reg
    import mux_pkg::*;
#(
    parameter int N_IN  = 6,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_scan_reg_if.slave bus
);
    localparam int SELW = sel_width(N_IN);
    localparam logic [SELW-1:0] PTR_LAST = SELW'(N_IN - 1);

    logic [N_IN-1:0][W-1:0] chan;
    assign chan = bus.in_data;

    mux_state_t      state, state_nxt;
    logic [SELW-1:0] ptr, ptr_nxt;
    logic            entering, hold, tick;

    logic [W-1:0]    data_q, data_nxt;
    logic            valid_q, valid_nxt;
    logic [SELW-1:0] ch_q, ch_nxt;
    logic            wrap_q, wrap_nxt;

    function automatic logic in_range(input logic [SELW-1:0] s);
        return 32'(s) < N_IN;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (bus.en)
            state_nxt = (bus.mode == MODE_SCAN) ? SCAN : MANUAL;
    end

    assign entering = (state_nxt == SCAN) && (state != SCAN);
    // Counter only runs while actively scanning; leaving SCAN keeps its value.
    assign hold     = (state_nxt != SCAN) || bus.freeze;

    mux_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (entering),
        .hold (hold),
        .tick (tick)
    );

    always_comb begin
        ptr_nxt   = ptr;
        ch_nxt    = ch_q;
        data_nxt  = '0;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        case (state_nxt)
            MANUAL: begin
                ch_nxt = bus.sel;
                if (in_range(bus.sel)) begin
                    data_nxt  = chan[bus.sel];
                    valid_nxt = bus.in_valid[bus.sel];
                end
            end
            SCAN: begin
                if (entering) begin
                    ptr_nxt = in_range(bus.sel) ? bus.sel : '0;
                end else if (tick) begin
                    if (ptr == PTR_LAST) begin
                        ptr_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        ptr_nxt = ptr + 1'b1;
                    end
                end
                // Output follows the updated pointer, giving one-cycle latency.
                ch_nxt    = ptr_nxt;
                data_nxt  = chan[ptr_nxt];
                valid_nxt = bus.in_valid[ptr_nxt];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ch_q    <= ch_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_ch    = ch_q;
    assign bus.scan_wrap = wrap_q;

`ifdef MUX_SEL_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (state_nxt == IDLE)
            err_q <= 1'b0;
        else if (state_nxt == MANUAL && !in_range(bus.sel))
            err_q <= 1'b1;
    end

    assign bus.sel_err = err_q;
`endif

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: table-driven manual checks, scan corner sequences,
// and randomized traffic against a position-from-elapsed-time model.
module tb_mux_scan_reg;
    import mux_pkg::*;

    localparam int NA = 6, WA = 8, DA = 4;
    localparam int NB = 2, WB = 4, DB = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_scan_reg_if #(.N_IN(NA), .W(WA)) ba();
    mux_scan_reg_if #(.N_IN(NB), .W(WB)) bb();

    mux_scan_reg #(.N_IN(NA), .W(WA), .DWELL(DA)) dut_a (.clk(clk), .rst(rst), .bus(ba));
    mux_scan_reg #(.N_IN(NB), .W(WB), .DWELL(DB)) dut_b (.clk(clk), .rst(rst), .bus(bb));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_a(input string nm, input int d, input int v, input int ch, input int w);
        chk({nm, ".data"},  32'(ba.out_data),  32'(d));
        chk({nm, ".valid"}, 32'(ba.out_valid), 32'(v));
        chk({nm, ".ch"},    32'(ba.out_ch),    32'(ch));
        chk({nm, ".wrap"},  32'(ba.scan_wrap), 32'(w));
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [5:0] vld;
        logic [7:0] e_data;
        logic       e_valid;
        logic [2:0] e_ch;
        logic       e_err;
    } vec_t;

    vec_t tbl[6];

    // Reference model state (DUT A, randomized phase)
    int m_prev, m_p0, m_k, m_ch, m_data, m_valid, m_wrap, m_err;

    task automatic model_step();
        int p;
        if (!ba.en) begin
            m_prev = 0; m_data = 0; m_valid = 0; m_wrap = 0; m_err = 0;
        end else if (!ba.mode) begin
            m_prev = 1; m_ch = int'(ba.sel); m_wrap = 0;
            if (int'(ba.sel) < NA) begin
                m_data  = int'(ba.in_data[int'(ba.sel)*WA +: WA]);
                m_valid = int'(ba.in_valid[int'(ba.sel)]);
            end else begin
                m_data = 0; m_valid = 0; m_err = 1;
            end
        end else begin
            m_wrap = 0;
            if (m_prev != 2) begin
                m_p0 = (int'(ba.sel) < NA) ? int'(ba.sel) : 0;
                m_k  = 0;
            end else if (!ba.freeze) begin
                m_k++;
                if ((m_k % DA) == 0 && ((m_p0 + m_k / DA) % NA) == 0) m_wrap = 1;
            end
            p       = (m_p0 + m_k / DA) % NA;
            m_prev  = 2;
            m_ch    = p;
            m_data  = int'(ba.in_data[p*WA +: WA]);
            m_valid = int'(ba.in_valid[p]);
        end
    endtask

    initial begin
        logic [5:0] sv;
        rst = 1'b1;
        ba.en = 0; ba.mode = 0; ba.freeze = 0; ba.sel = '0; ba.in_valid = '1;
        for (int k = 0; k < NA; k++) ba.in_data[k*WA +: WA] = 8'h10 + 8'(k);
        bb.en = 0; bb.mode = 0; bb.freeze = 0; bb.sel = '0;
        bb.in_data = {4'hB, 4'hA}; bb.in_valid = 2'b10;

        // Reset state
        repeat (2) @(negedge clk);
        chk_a("rst", 0, 0, 0, 0);
`ifdef MUX_SEL_ERR_EN
        chk("rst.err", 32'(ba.sel_err), 0);
`endif
        rst = 1'b0;
        cyc();
        chk_a("idle0", 0, 0, 0, 0);

        // Manual select table
        tbl[0] = '{3'd4, 6'h3f,      8'h14, 1'b1, 3'd4, 1'b0};
        tbl[1] = '{3'd7, 6'h3f,      8'h00, 1'b0, 3'd7, 1'b1};
        tbl[2] = '{3'd0, 6'b111110,  8'h10, 1'b0, 3'd0, 1'b1};
        tbl[3] = '{3'd5, 6'h3f,      8'h15, 1'b1, 3'd5, 1'b1};
        tbl[4] = '{3'd6, 6'h3f,      8'h00, 1'b0, 3'd6, 1'b1};
        tbl[5] = '{3'd2, 6'b000100,  8'h12, 1'b1, 3'd2, 1'b1};
        ba.en = 1; ba.mode = MODE_MANUAL;
        for (int i = 0; i < 6; i++) begin
            ba.sel = tbl[i].sel; ba.in_valid = tbl[i].vld;
            cyc();
            chk_a($sformatf("man%0d", i), int'(tbl[i].e_data), int'(tbl[i].e_valid),
                  int'(tbl[i].e_ch), 0);
`ifdef MUX_SEL_ERR_EN
            chk($sformatf("man%0d.err", i), 32'(ba.sel_err), 32'(tbl[i].e_err));
`endif
        end
        ba.en = 0;
        cyc();
        chk_a("idle1", 0, 0, 2, 0);
`ifdef MUX_SEL_ERR_EN
        chk("idle1.err", 32'(ba.sel_err), 0);
`endif

        // Full scan sequence with valid qualification
        sv = 6'b101101;
        ba.en = 1; ba.mode = MODE_SCAN; ba.sel = 0; ba.in_valid = sv;
        for (int i = 0; i < 26; i++) begin
            int ch;
            cyc();
            ch = (i / DA) % NA;
            chk_a($sformatf("scan%0d", i), 8'h10 + ch, int'(sv[ch]), ch, (i == 24) ? 1 : 0);
        end

        // Freeze at ptr=2 with cnt=1
        ba.en = 0; cyc();
        ba.en = 1; ba.sel = 2; cyc(); cyc();
        ba.freeze = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("frz%0d.ch", i), 32'(ba.out_ch), 2);
            chk($sformatf("frz%0d.wrap", i), 32'(ba.scan_wrap), 0);
        end
        ba.freeze = 0;
        cyc(); chk("unfrz0.ch", 32'(ba.out_ch), 2);
        cyc(); chk("unfrz1.ch", 32'(ba.out_ch), 2);
        cyc(); chk("unfrz2.ch", 32'(ba.out_ch), 3);

        // Mode switching scan -> manual -> scan
        ba.en = 0; cyc();
        ba.en = 1; ba.sel = 3; cyc(); cyc();
        chk("sw.scan.ch", 32'(ba.out_ch), 3);
        ba.mode = MODE_MANUAL; ba.sel = 1; cyc();
        chk_a("sw.man", 8'h11, 0, 1, 0);
        ba.mode = MODE_SCAN; ba.sel = 5; cyc();
        chk_a("sw.entry", 8'h15, 1, 5, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("sw.hold%0d", i), 32'(ba.out_ch), 5);
        end
        cyc(); chk_a("sw.wrap", 8'h10, 1, 0, 1);
        cyc(); chk_a("sw.after", 8'h10, 1, 0, 0);

        // en drop on the wrap edge
        ba.en = 0; cyc();
        ba.en = 1; ba.sel = 5; cyc(); cyc(); cyc(); cyc();
        ba.en = 0; cyc();
        chk_a("endrop", 0, 0, 5, 0);

        // Async reset mid-scan
        ba.en = 1; ba.sel = 3; cyc(); cyc();
        rst = 1'b1;
        #1;
        chk_a("arst", 0, 0, 0, 0);
        ba.en = 0;
        @(negedge clk); rst = 1'b0;
        cyc();
        chk_a("arst.rel", 0, 0, 0, 0);

        // DUT B: DWELL=1, N_IN=2
        bb.en = 1; bb.mode = MODE_SCAN; bb.sel = 0;
        for (int i = 0; i < 8; i++) begin
            int ch;
            cyc();
            ch = i % 2;
            chk($sformatf("b%0d.ch", i),    32'(bb.out_ch),    32'(ch));
            chk($sformatf("b%0d.wrap", i),  32'(bb.scan_wrap), (i > 0 && ch == 0) ? 1 : 0);
            chk($sformatf("b%0d.data", i),  32'(bb.out_data),  ch ? 32'hB : 32'hA);
            chk($sformatf("b%0d.valid", i), 32'(bb.out_valid), 32'(ch));
        end
        bb.en = 0; cyc();
        chk("b.endrop.wrap",  32'(bb.scan_wrap), 0);
        chk("b.endrop.valid", 32'(bb.out_valid), 0);
        chk("b.endrop.ch",    32'(bb.out_ch),    1);
`ifdef MUX_SEL_ERR_EN
        bb.en = 1; bb.mode = MODE_MANUAL; bb.sel = 1; cyc();
        chk("b.err", 32'(bb.sel_err), 0);
`endif

        // Randomized traffic against the model
        rst = 1'b1; ba.en = 0; ba.freeze = 0;
        @(negedge clk); rst = 1'b0;
        m_prev = 0; m_p0 = 0; m_k = 0; m_ch = 0; m_data = 0; m_valid = 0; m_wrap = 0; m_err = 0;
        for (int i = 0; i < 400; i++) begin
            ba.en       = ($urandom % 10) != 0;
            if ($urandom % 16 == 0) ba.mode = ~ba.mode;
            ba.freeze   = ($urandom % 5) == 0;
            ba.sel      = 3'($urandom % 8);
            ba.in_data  = 48'({$urandom, $urandom});
            ba.in_valid = 6'($urandom);
            cyc();
            model_step();
            chk_a($sformatf("rnd%0d", i), m_data, m_valid, m_ch, m_wrap);
`ifdef MUX_SEL_ERR_EN
            chk($sformatf("rnd%0d.err", i), 32'(ba.sel_err), 32'(m_err));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
